err_pos_gen: RTL and testbench

ERR_POS_GEN -- requirements
Module: err_pos_gen

---
 rtl/err_pos_gen.sv | 174 +++++++++++++++++
 tb/tb_err_pos_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/err_pos_gen.sv
// err_pos_gen: draws T distinct error positions in 0..N-1 from an upstream PRNG.
// Each candidate is requested, waited for, range-checked, scanned against the
// positions already accepted in this run, and handed downstream on a
// valid/ready port. Out-of-range and duplicate candidates are counted and
// redrawn.

`ifndef PRNG_TYP_W
`define PRNG_TYP_W 2
`endif
`ifndef PRNG_DAT_W
`define PRNG_DAT_W 32
`endif

module err_pos_gen #(
    parameter int N        = 2048,
    parameter int T        = 27,
    parameter int POS_W    = 11,
    parameter int PRNG_LAT = 6
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   start,
    output logic [`PRNG_TYP_W-1:0] prng_typ_sel,
    input  logic [`PRNG_DAT_W-1:0] prng_r_dat,
    output logic [POS_W-1:0]       pos_dat,
    output logic                   pos_valid,
    input  logic                   pos_ready,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            rej_cnt
);

    localparam int CNT_W  = $clog2(T + 1);
    localparam int WAIT_W = (PRNG_LAT > 1) ? $clog2(PRNG_LAT) : 1;

    localparam logic [POS_W:0]            N_L       = N[POS_W:0];
    localparam logic [CNT_W-1:0]          T_LAST    = CNT_W'(T - 1);
    localparam logic [WAIT_W-1:0]         WAIT_LAST = WAIT_W'(PRNG_LAT - 1);
    localparam logic [`PRNG_TYP_W-1:0]    TYP_HALT  = '0;
    localparam logic [`PRNG_TYP_W-1:0]    TYP_GEN   = 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CHECK,
        EMIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  chk_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [POS_W-1:0]  cand;
    logic [POS_W-1:0]  list [T];

    logic out_of_range;
    logic list_empty;
    logic is_match;
    logic scan_last;
    logic last_wait;
    logic chk_reject;
    logic chk_pass;
    logic xfer;
    logic run_end;

    // Only the low POS_W bits of the PRNG word form a candidate.
    if (POS_W < `PRNG_DAT_W) begin : g_prng_hi
        logic prng_hi_unused;
        assign prng_hi_unused = ^prng_r_dat[`PRNG_DAT_W-1:POS_W];
    end

    assign out_of_range = ({1'b0, cand} >= N_L);
    assign list_empty   = (acc_cnt == '0);
    assign is_match     = (list[chk_idx] == cand);
    assign scan_last    = (chk_idx == acc_cnt - 1'b1);
    assign last_wait    = (wait_cnt == WAIT_LAST);
    assign run_end      = (acc_cnt == T_LAST);
    assign xfer         = (state == EMIT) && pos_ready;

    // A candidate is rejected on range first, then on the first matching entry;
    // it passes once the last live entry has been compared without a match.
    assign chk_reject = (state == CHECK) && (out_of_range || (!list_empty && is_match));
    assign chk_pass   = (state == CHECK) && !out_of_range
                        && (list_empty || (!is_match && scan_last));

    assign pos_dat = cand;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
        if (rst_b) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    if (last_wait) state_nxt = CHECK;
            CHECK: begin
                if (chk_reject)    state_nxt = REQ;
                else if (chk_pass) state_nxt = EMIT;
            end
            EMIT:    if (pos_ready) state_nxt = run_end ? IDLE : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore/Mealy outputs; valid and done are masked while reset aborts the run.
    always_comb begin
        prng_typ_sel = TYP_HALT;
        pos_valid    = 1'b0;
        done         = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            REQ:     prng_typ_sel = TYP_GEN;
            EMIT: begin
                pos_valid = !rst_b;
                done      = pos_ready && run_end && !rst_b;
            end
            default: ;
        endcase
    end

    // Run counters, wait timer, scan index and the latched candidate.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            acc_cnt  <= '0;
            rej_cnt  <= '0;
            wait_cnt <= '0;
            chk_idx  <= '0;
            cand     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_cnt <= '0;
                        rej_cnt <= '0;
                    end
                end
                REQ:  wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (last_wait) begin
                        cand    <= prng_r_dat[POS_W-1:0];
                        chk_idx <= '0;
                    end
                end
                CHECK: begin
                    if (chk_reject) begin
                        if (rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 16'd1;
                    end else if (!chk_pass) begin
                        chk_idx <= chk_idx + 1'b1;
                    end
                end
                EMIT: if (pos_ready) acc_cnt <= acc_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Accepted-position list; only entries below acc_cnt are ever compared.
    always_ff @(posedge clk) begin
        // NOTE: memory is deliberately not reset; acc_cnt alone defines which entries are live.
        if (!rst_b && xfer) list[acc_cnt] <= cand;
    end

endmodule

// File: tb/tb_err_pos_gen.sv
// Bench for err_pos_gen: two instances (N=2048/T=3 and N=1800/T=2), a PRNG
// model that presents each word only on the cycle it must be sampled, and a
// scoreboard monitor that pops expected positions on every transfer.

`ifndef PRNG_TYP_W
`define PRNG_TYP_W 2
`endif
`ifndef PRNG_DAT_W
`define PRNG_DAT_W 32
`endif

module tb_err_pos_gen;

    localparam int          PRNG_LAT = 6;
    localparam logic [31:0] GARBAGE  = 32'h0000_0123;

    logic                   clk = 1'b0;
    logic                   rst_b     [2];
    logic                   start     [2];
    logic                   pos_ready [2];
    logic                   pos_valid [2];
    logic                   busy      [2];
    logic                   done      [2];
    logic [`PRNG_TYP_W-1:0] typ       [2];
    logic [`PRNG_DAT_W-1:0] prng_dat  [2];
    logic [10:0]            pos_dat   [2];
    logic [15:0]            rej_cnt   [2];

    logic [31:0] word_q [2][$];
    logic [10:0] exp_q  [2][$];
    int          done_cnt [2] = '{0, 0};
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    err_pos_gen #(.N(2048), .T(3), .POS_W(11), .PRNG_LAT(PRNG_LAT)) u_a (
        .clk(clk), .rst_b(rst_b[0]), .start(start[0]), .prng_typ_sel(typ[0]),
        .prng_r_dat(prng_dat[0]), .pos_dat(pos_dat[0]), .pos_valid(pos_valid[0]),
        .pos_ready(pos_ready[0]), .busy(busy[0]), .done(done[0]), .rej_cnt(rej_cnt[0])
    );

    err_pos_gen #(.N(1800), .T(2), .POS_W(11), .PRNG_LAT(PRNG_LAT)) u_b (
        .clk(clk), .rst_b(rst_b[1]), .start(start[1]), .prng_typ_sel(typ[1]),
        .prng_r_dat(prng_dat[1]), .pos_dat(pos_dat[1]), .pos_valid(pos_valid[1]),
        .pos_ready(pos_ready[1]), .busy(busy[1]), .done(done[1]), .rej_cnt(rej_cnt[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_env
        // PRNG model: word appears only during the last WAIT cycle after a trigger.
        initial begin
            logic [31:0] w;
            prng_dat[g] = GARBAGE;
            forever begin
                @(negedge clk);
                if (typ[g] == 1) begin
                    if (word_q[g].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL prng_underflow[%0d]: got extra trigger expected none", g);
                        w = GARBAGE;
                    end else begin
                        w = word_q[g].pop_front();
                    end
                    @(negedge clk);
                    check($sformatf("trigger_width[%0d]", g), typ[g], 0);
                    repeat (PRNG_LAT - 1) @(negedge clk);
                    prng_dat[g] = w;
                    @(negedge clk);
                    prng_dat[g] = GARBAGE;
                end
            end
        end

        // Scoreboard monitor: compare every transfer with the next expected position.
        initial begin
            forever begin
                @(negedge clk);
                if (done[g] === 1'b1) done_cnt[g]++;
                if (pos_valid[g] === 1'b1 && pos_ready[g] === 1'b1) begin
                    if (exp_q[g].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pos[%0d]: got %0d expected none", g, pos_dat[g]);
                    end else begin
                        check($sformatf("pos_dat[%0d]", g), pos_dat[g], exp_q[g].pop_front());
                    end
                end
            end
        end
    end

    task automatic pulse_start(input int g);
        @(posedge clk); #1 start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
    endtask

    // Counts cycles (first = REQ cycle) until done is seen, bounded by budget.
    task automatic run_wait(input int g, input int budget, output int cycles);
        bit found = 0;
        cycles = 0;
        while (!found && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done[g] === 1'b1) found = 1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL done_timeout[%0d]: got no done expected done within %0d", g, budget);
        end
    endtask

    task automatic wait_valid(input int g, input int budget);
        int n = 0;
        while (pos_valid[g] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pos_valid[g] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL valid_timeout[%0d]: got no pos_valid expected within %0d", g, budget);
        end
    endtask

    task automatic check_reset_outputs(input int g, input string tag);
        check({tag, "_typ"},   typ[g],       0);
        check({tag, "_valid"}, pos_valid[g], 0);
        check({tag, "_dat"},   pos_dat[g],   0);
        check({tag, "_busy"},  busy[g],      0);
        check({tag, "_done"},  done[g],      0);
        check({tag, "_rej"},   rej_cnt[g],   0);
    endtask

    task automatic check_run_end(input int g, input string tag, input int rej, input int dones);
        check({tag, "_busy_on_done"}, busy[g], 1);
        @(negedge clk);
        check({tag, "_busy_after"}, busy[g], 0);
        check({tag, "_done_width"}, done[g], 0);
        check({tag, "_rej"},        rej_cnt[g], rej);
        check({tag, "_done_cnt"},   done_cnt[g], dones);
        check({tag, "_exp_left"},   exp_q[g].size(), 0);
        check({tag, "_words_left"}, word_q[g].size(), 0);
    endtask

    initial begin
        int n;
        for (int g = 0; g < 2; g++) begin
            rst_b[g]     = 1'b1;
            start[g]     = 1'b0;
            pos_ready[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs(0, "rst_a");
        check_reset_outputs(1, "rst_b");
        @(posedge clk); #1;
        rst_b[0] = 1'b0;
        rst_b[1] = 1'b0;

        // Duplicate rejection and truncation of upper PRNG bits.
        word_q[0].push_back(32'd5);
        word_q[0].push_back(32'd9);
        word_q[0].push_back(32'd5);
        word_q[0].push_back(32'hA5A5_07FF);
        exp_q[0].push_back(11'd5);
        exp_q[0].push_back(11'd9);
        exp_q[0].push_back(11'd2047);
        pulse_start(0);
        run_wait(0, 200, n);
        check("t1_latency", n, 36);
        check_run_end(0, "t1", 1, 1);

        // Back-pressure in EMIT, start ignored in EMIT and WAIT.
        @(posedge clk); #1 pos_ready[0] = 1'b0;
        word_q[0].push_back(32'd100);
        word_q[0].push_back(32'd200);
        word_q[0].push_back(32'd300);
        exp_q[0].push_back(11'd100);
        exp_q[0].push_back(11'd200);
        exp_q[0].push_back(11'd300);
        pulse_start(0);
        wait_valid(0, 50);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 start[0] = (i == 4);
            @(negedge clk);
            check("t2_stall_valid", pos_valid[0], 1);
            check("t2_stall_dat",   pos_dat[0],   100);
            check("t2_stall_typ",   typ[0],       0);
        end
        @(posedge clk); #1;
        start[0]     = 1'b0;
        pos_ready[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        run_wait(0, 200, n);
        check("t2_latency_tail", n, 17);
        check_run_end(0, "t2", 0, 2);

        // Reset during EMIT of the second position, then a fresh run.
        word_q[0].push_back(32'd7);
        word_q[0].push_back(32'd11);
        exp_q[0].push_back(11'd7);
        pulse_start(0);
        wait_valid(0, 50);
        @(posedge clk); #1 pos_ready[0] = 1'b0;
        wait_valid(0, 50);
        check("t3_second_pos", pos_dat[0], 11);
        @(posedge clk); #1 rst_b[0] = 1'b1;
        @(posedge clk); #1 rst_b[0] = 1'b0;
        @(negedge clk);
        check_reset_outputs(0, "t3_rst");
        @(posedge clk); #1 pos_ready[0] = 1'b1;
        word_q[0].push_back(32'd7);
        word_q[0].push_back(32'd200);
        word_q[0].push_back(32'd300);
        exp_q[0].push_back(11'd7);
        exp_q[0].push_back(11'd200);
        exp_q[0].push_back(11'd300);
        pulse_start(0);
        run_wait(0, 200, n);
        check("t3_latency", n, 28);
        check_run_end(0, "t3", 0, 3);

        // Range rejection with N=1800.
        word_q[1].push_back(32'd1900);
        word_q[1].push_back(32'd1799);
        word_q[1].push_back(32'd1800);
        word_q[1].push_back(32'd0);
        exp_q[1].push_back(11'd1799);
        exp_q[1].push_back(11'd0);
        pulse_start(1);
        run_wait(1, 200, n);
        check("t4_latency", n, 34);
        check_run_end(1, "t4", 2, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
